// File: rtl/hex_loader_if.sv
// Bus bundle for hex_loader: UART line in, BRAM write port and status pulses out.
interface hex_loader_if #(
    parameter int ADDR_W = 8
);
    logic              rx;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              line_done;
    logic              err;
    logic              frame_err;
    logic              busy;

    // Loader side: consumes the serial line, drives the write port.
    modport master (
        input  rx,
        output wr_en, wr_addr, wr_data, line_done, err, frame_err, busy
    );

    // Host / memory side: drives the serial line, receives writes.
    modport slave (
        output rx,
        input  wr_en, wr_addr, wr_data, line_done, err, frame_err, busy
    );
endinterface

// File: rtl/hex_loader.sv
// UART 8N1 receiver feeding an ASCII hex-record parser ("$AA#DDDD..\r").
// Each complete hex byte pair becomes a one-cycle BRAM write with an
// auto-incrementing 8-bit address.
module hex_loader #(
    parameter int CLK_DIV = 208,
    parameter int ADDR_W  = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    hex_loader_if.master bus
);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLK_DIV / 2 - 1);

    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_HASH   = 8'h23;
    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_CR     = 8'h0D;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
    typedef enum logic [2:0] {P_IDLE, P_ADDR_HI, P_ADDR_LO, P_SEP,
                              P_DATA_HI, P_DATA_LO} p_state_e;

    // ---------------- receiver ----------------
    logic            rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_e       rstate_q;
    logic [CNT_W-1:0] baud_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            byte_stb_q;
    logic            ferr_stb_q;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= bus.rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    // Bit-timing FSM: centre-samples start, 8 data bits LSB first, stop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rstate_q   <= R_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            byte_stb_q <= 1'b0;
            ferr_stb_q <= 1'b0;
        end else begin
            byte_stb_q <= 1'b0;
            ferr_stb_q <= 1'b0;
            case (rstate_q)
                R_IDLE: begin
                    baud_q <= '0;
                    bit_q  <= '0;
                    if (rx_prev_q && !rx_s2_q) rstate_q <= R_START;
                end
                R_START: begin
                    if (baud_q == HALF_M1) begin
                        baud_q   <= '0;
                        // A line already back high at mid-bit is a glitch.
                        rstate_q <= rx_s2_q ? R_IDLE : R_DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                R_DATA: begin
                    if (baud_q == FULL_M1) begin
                        baud_q  <= '0;
                        shift_q <= {rx_s2_q, shift_q[7:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == 3'd7) rstate_q <= R_STOP;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                R_STOP: begin
                    if (baud_q == FULL_M1) begin
                        baud_q     <= '0;
                        byte_stb_q <= rx_s2_q;
                        ferr_stb_q <= !rx_s2_q;
                        rstate_q   <= R_IDLE;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    // ---------------- hex decode ----------------
    logic       is_hex_d;
    logic [3:0] nib_d;

    // ASCII hex digit to nibble; is_hex_d flags a valid digit.
    always_comb begin
        is_hex_d = 1'b0;
        nib_d    = 4'h0;
        if (shift_q >= 8'h30 && shift_q <= 8'h39) begin
            is_hex_d = 1'b1;
            nib_d    = shift_q[3:0];
        end else if ((shift_q >= 8'h41 && shift_q <= 8'h46) ||
                     (shift_q >= 8'h61 && shift_q <= 8'h66)) begin
            is_hex_d = 1'b1;
            nib_d    = shift_q[3:0] + 4'd9;
        end
    end

    // ---------------- parser ----------------
    p_state_e          pstate_q;
    logic [7:0]        addr_q;
    logic [3:0]        hi_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic              err_q, line_done_q, frame_err_q, busy_q;

    // Record parser; all outputs registered one cycle after the byte strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pstate_q    <= P_IDLE;
            addr_q      <= '0;
            hi_q        <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            err_q       <= 1'b0;
            line_done_q <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            wr_en_q     <= 1'b0;
            err_q       <= 1'b0;
            line_done_q <= 1'b0;
            frame_err_q <= ferr_stb_q;
            busy_q      <= (pstate_q != P_IDLE);
            if (byte_stb_q) begin
                if (shift_q == CH_DOLLAR) begin
                    // Resync: any half-built byte is silently dropped.
                    pstate_q <= P_ADDR_HI;
                end else begin
                    case (pstate_q)
                        P_IDLE: ;
                        P_ADDR_HI: begin
                            if (is_hex_d) begin
                                addr_q[7:4] <= nib_d;
                                pstate_q    <= P_ADDR_LO;
                            end else begin
                                err_q    <= 1'b1;
                                pstate_q <= P_IDLE;
                            end
                        end
                        P_ADDR_LO: begin
                            if (is_hex_d) begin
                                addr_q[3:0] <= nib_d;
                                pstate_q    <= P_SEP;
                            end else begin
                                err_q    <= 1'b1;
                                pstate_q <= P_IDLE;
                            end
                        end
                        P_SEP: begin
                            if (shift_q == CH_HASH) begin
                                pstate_q <= P_DATA_HI;
                            end else begin
                                err_q    <= 1'b1;
                                pstate_q <= P_IDLE;
                            end
                        end
                        P_DATA_HI: begin
                            if (is_hex_d) begin
                                hi_q     <= nib_d;
                                pstate_q <= P_DATA_LO;
                            end else if (shift_q == CH_SPACE || shift_q == CH_LF) begin
                                pstate_q <= P_DATA_HI;
                            end else if (shift_q == CH_CR) begin
                                line_done_q <= 1'b1;
                                pstate_q    <= P_IDLE;
                            end else begin
                                err_q    <= 1'b1;
                                pstate_q <= P_IDLE;
                            end
                        end
                        P_DATA_LO: begin
                            if (is_hex_d) begin
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= ADDR_W'(addr_q);
                                wr_data_q <= {hi_q, nib_d};
                                addr_q    <= addr_q + 8'd1;
                                pstate_q  <= P_DATA_HI;
                            end else begin
                                err_q    <= 1'b1;
                                pstate_q <= P_IDLE;
                            end
                        end
                        default: pstate_q <= P_IDLE;
                    endcase
                end
            end
        end
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.line_done = line_done_q;
    assign bus.err       = err_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;
endmodule
